// File: rtl/if_fetch_unit_pkg.sv
// Shared CPU definitions used by the instruction-fetch stage: exception codes,
// fixed PCs, the legal text-segment window and the fetch FSM encoding.
package if_fetch_unit_pkg;

  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  localparam logic [31:0] CPU_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] CPU_HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] CPU_TEXT_LO    = 32'h0000_3000;
  localparam logic [31:0] CPU_TEXT_HI    = 32'h0000_6ffc;

  typedef enum logic {
    S_REQ   = 1'b0,
    S_VALID = 1'b1
  } fetch_state_e;

  // A fetch is legal only when word-aligned and inside the text window (unsigned).
  function automatic logic fetch_addr_ok(input logic [31:0] addr,
                                         input logic [31:0] lo,
                                         input logic [31:0] hi);
    return (addr[1:0] == 2'b00) && (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface if_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );

endinterface

// File: rtl/if_next_pc.sv
// Next-PC selection for the fetch stage: exception entry, eret, taken branch,
// or sequential pc+4 with 32-bit wrap.
module if_next_pc #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] pc,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc + 32'd4;
    if (req) begin
      next_pc = HANDLER_PC;
    end else if (eret) begin
      next_pc = epc;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem handshake and presents
// PC/instruction/ExcCode/BD to the IF/ID register.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = CPU_RESET_PC,
  parameter logic [31:0] HANDLER_PC = CPU_HANDLER_PC,
  parameter logic [31:0] TEXT_LO    = CPU_TEXT_LO,
  parameter logic [31:0] TEXT_HI    = CPU_TEXT_HI
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   req,
  input  logic                   eret,
  input  logic [31:0]            epc,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  input  logic                   id_is_branch,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            IF_PC,
  output logic [31:0]            IF_instr,
  output logic [4:0]             IF_ExcCode,
  output logic                   IF_BD,
  output logic                   if_busy
);

  fetch_state_e state_p0, state_d;
  logic [31:0]  pc_p0, pc_d;
  logic [31:0]  instr_buf_p0, instr_buf_d;
  logic [4:0]   exc_buf_p0, exc_buf_d;
  logic [31:0]  next_pc;
  logic         addr_ok;
  logic         vld_p0;

  assign addr_ok = fetch_addr_ok(pc_p0, TEXT_LO, TEXT_HI);
  assign vld_p0  = (state_p0 == S_VALID);

  if_next_pc #(
    .HANDLER_PC(HANDLER_PC)
  ) u_next_pc (
    .req          (req),
    .eret         (eret),
    .epc          (epc),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pc           (pc_p0),
    .next_pc      (next_pc)
  );

  // An exception request overrides everything, including a coincident ack,
  // and restarts fetching at the handler regardless of stall.
  always_comb begin
    state_d     = state_p0;
    pc_d        = pc_p0;
    instr_buf_d = instr_buf_p0;
    exc_buf_d   = exc_buf_p0;
    if (req) begin
      pc_d    = next_pc;
      state_d = S_REQ;
    end else begin
      case (state_p0)
        S_REQ: begin
          if (!addr_ok) begin
            instr_buf_d = '0;
            exc_buf_d   = EXC_ADEL;
            state_d     = S_VALID;
          end else if (imem.imem_ack) begin
            instr_buf_d = imem.imem_rdata;
            exc_buf_d   = EXC_NONE;
            state_d     = S_VALID;
          end
        end
        S_VALID: begin
          if (!stall) begin
            pc_d    = next_pc;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // Stage p0: PC, FSM state and presented instruction/exception buffers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p0     <= S_REQ;
      pc_p0        <= RESET_PC;
      instr_buf_p0 <= '0;
      exc_buf_p0   <= EXC_NONE;
    end else begin
      state_p0     <= state_d;
      pc_p0        <= pc_d;
      instr_buf_p0 <= instr_buf_d;
      exc_buf_p0   <= exc_buf_d;
    end
  end

  assign imem.imem_req  = (state_p0 == S_REQ) && addr_ok;
  assign imem.imem_addr = pc_p0;

  assign IF_PC      = pc_p0;
  assign IF_instr   = vld_p0 ? instr_buf_p0 : 32'd0;
  assign IF_ExcCode = vld_p0 ? exc_buf_p0 : EXC_NONE;
  assign IF_BD      = id_is_branch && vld_p0;
  assign if_busy    = !vld_p0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the fetch stage.
module tb_if_fetch_unit;

  localparam logic [31:0] HANDLER = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, req, eret, branch_taken, id_is_branch;
  logic [31:0] epc, branch_target;
  logic [31:0] IF_PC, IF_instr;
  logic [4:0]  IF_ExcCode;
  logic        IF_BD, if_busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc;
  logic        m_vld;

  if_fetch_unit_if imem ();

  if_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .req          (req),
    .eret         (eret),
    .epc          (epc),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .id_is_branch (id_is_branch),
    .imem         (imem),
    .IF_PC        (IF_PC),
    .IF_instr     (IF_instr),
    .IF_ExcCode   (IF_ExcCode),
    .IF_BD        (IF_BD),
    .if_busy      (if_busy)
  );

  always #5 clk = ~clk;

  function automatic logic legal(input logic [31:0] a);
    return (a % 4 == 0) && (a >= 32'h3000) && (a <= 32'h6ffc);
  endfunction

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h3000) return 32'h2408_0001;
    return (a * 32'h9E37_79B9) + 32'h1234_5677;
  endfunction

  function automatic logic [31:0] rand_target();
    int k;
    logic [31:0] base;
    k = $urandom_range(0, 9);
    base = 32'h3000 + ({20'h0, 12'($urandom_range(0, 4095))} << 2);
    if (k == 0) return base + 32'($urandom_range(1, 3));
    if (k == 1) return $urandom;
    if (k == 2) return 32'h6ff8;
    return base;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("if_busy", 32'(if_busy), 32'(!m_vld));
    check("IF_PC", IF_PC, m_pc);
    check("imem_req", 32'(imem.imem_req), 32'(!m_vld && legal(m_pc)));
    if (!m_vld) check("imem_addr", imem.imem_addr, m_pc);
    check("IF_instr", IF_instr, (m_vld && legal(m_pc)) ? mem(m_pc) : 32'd0);
    check("IF_ExcCode", 32'(IF_ExcCode), (m_vld && !legal(m_pc)) ? 32'd4 : 32'd0);
  endtask

  // Inputs are already set for the coming edge; the bench plays memory.
  task automatic cycle(input bit ack);
    imem.imem_ack   = ack && imem.imem_req;
    imem.imem_rdata = mem(imem.imem_addr);
    #1;
    check("IF_BD", 32'(IF_BD), 32'(id_is_branch && m_vld));
    if (req) begin
      m_pc  = HANDLER;
      m_vld = 1'b0;
    end else if (m_vld) begin
      if (!stall) begin
        m_pc  = eret ? epc : branch_taken ? branch_target : m_pc + 32'd4;
        m_vld = 1'b0;
      end
    end else if (!legal(m_pc) || imem.imem_ack) begin
      m_vld = 1'b1;
    end
    @(posedge clk);
    #1;
    imem.imem_ack = 1'b0;
    check_outputs();
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; req = 1'b0; eret = 1'b0; branch_taken = 1'b0;
    id_is_branch = 1'b1; epc = '0; branch_target = '0;
    imem.imem_ack = 1'b0; imem.imem_rdata = '0;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_IF_PC", IF_PC, 32'h3000);
    check("rst_IF_instr", IF_instr, 32'd0);
    check("rst_ExcCode", 32'(IF_ExcCode), 32'd0);
    check("rst_IF_BD", 32'(IF_BD), 32'd0);
    check("rst_busy", 32'(if_busy), 32'd1);
    id_is_branch = 1'b0;
    reset = 1'b1;
    m_pc = 32'h3000; m_vld = 1'b0;
    check_outputs();

    // First fetch acked after two cycles
    cycle(0);
    cycle(1);
    check("first_instr", IF_instr, 32'h2408_0001);

    // Stall holds the presented instruction
    stall = 1'b1;
    repeat (4) cycle(0);
    stall = 1'b0;
    cycle(0);
    check("seq_addr", imem.imem_addr, 32'h3004);

    // Delay slot then taken branch
    id_is_branch = 1'b1;
    cycle(1);
    branch_taken = 1'b1; branch_target = 32'h3100;
    cycle(0);
    id_is_branch = 1'b0; branch_taken = 1'b0;
    cycle(1);

    // Misaligned and out-of-range targets raise AdEL without a request
    branch_taken = 1'b1; branch_target = 32'h3102;
    cycle(0);
    branch_taken = 1'b0;
    cycle(0);
    check("adel_pc", IF_PC, 32'h3102);
    branch_taken = 1'b1; branch_target = 32'h7000;
    cycle(0);
    branch_taken = 1'b0;
    cycle(0);

    // Exception request beats coincident ack, eret and branch
    branch_taken = 1'b1; branch_target = 32'h3200;
    cycle(0);
    branch_taken = 1'b0;
    cycle(0);
    req = 1'b1; eret = 1'b1; epc = 32'h3208; branch_taken = 1'b1; branch_target = 32'h3300;
    cycle(1);
    req = 1'b0; eret = 1'b0; branch_taken = 1'b0;
    check("handler_addr", imem.imem_addr, HANDLER);
    cycle(1);

    // eret redirect, then async reset mid-request
    eret = 1'b1; epc = 32'h3208;
    cycle(0);
    eret = 1'b0;
    reset = 1'b0;
    #1;
    check("areset_IF_PC", IF_PC, 32'h3000);
    check("areset_instr", IF_instr, 32'd0);
    check("areset_addr", imem.imem_addr, 32'h3000);
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_pc = 32'h3000; m_vld = 1'b0;
    check_outputs();

    // Sequential wrap from the top of the address space
    cycle(1);
    branch_taken = 1'b1; branch_target = 32'hffff_fffc;
    cycle(0);
    branch_taken = 1'b0;
    cycle(0);
    cycle(0);
    check("wrap_pc", IF_PC, 32'h0);
    cycle(0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      stall         = ($urandom_range(0, 2) == 0);
      req           = ($urandom_range(0, 19) == 0);
      eret          = ($urandom_range(0, 7) == 0);
      epc           = rand_target();
      branch_taken  = ($urandom_range(0, 3) == 0);
      branch_target = rand_target();
      id_is_branch  = $urandom_range(0, 1) == 1;
      cycle($urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage; the producer side of the IF/ID pipeline register.
- Owns the PC and the instruction-memory request handshake.
- Presents IF_PC, IF_instr, IF_ExcCode and IF_BD for IF/ID to capture.
- Redirects the PC on branch, eret and exception/interrupt request, and flags fetch address errors (AdEL) for CP0.

Parameters:
RESET_PC, 32'h0000_3000, PC after reset
HANDLER_PC, 32'h0000_4180, exception/interrupt entry PC
TEXT_LO, 32'h0000_3000, lowest legal fetch address
TEXT_HI, 32'h0000_6ffc, highest legal fetch address (inclusive)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
stall  in  1  hazard-unit hold; IF/ID not accepting this cycle
req  in  1  CP0 exception/interrupt request
eret  in  1  eret in ID, proceeding this cycle
epc  in  32  return PC for eret
branch_taken  in  1  branch/jump in ID is taken
branch_target  in  32  target of taken branch/jump
id_is_branch  in  1  ID holds a branch/jump; IF instruction is its delay slot
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (word-aligned)
imem_rdata  in  32  fetched instruction, valid with imem_ack
imem_ack  in  1  single-cycle fetch completion
IF_PC  out  32  PC of instruction presented
IF_instr  out  32  instruction presented (0 = nop when not valid or on error)
IF_ExcCode  out  5  0 normal, 5'd4 AdEL
IF_BD  out  1  presented instruction is a delay slot
if_busy  out  1  fetch in progress; hazard unit ORs this into stall

Behaviour:
- Reset (reset==0, async): pc=RESET_PC, instr_buf=0, exc_buf=0, state=S_REQ. All outputs derive from these.
  - IF_instr=0, IF_ExcCode=0, IF_BD=0, if_busy=1 while reset is low.
- addr_ok = (pc[1:0]==0) && pc>=TEXT_LO && pc<=TEXT_HI. Comparisons are unsigned.
- FSM with 2 states:
  - S_REQ:
    - if_busy=1. imem_addr=pc. imem_req=addr_ok.
    - addr_ok && imem_ack: instr_buf<=imem_rdata, exc_buf<=0, go S_VALID.
    - !addr_ok: no request issued. Next cycle instr_buf<=0, exc_buf<=4, go S_VALID. Latency is 1 cycle.
    - Otherwise stay in S_REQ. imem_req stays high and imem_addr stays stable until ack.
  - S_VALID:
    - if_busy=0, imem_req=0. Outputs present instr_buf/exc_buf.
    - stall=1: hold everything.
    - stall=0 (IF/ID captures this edge): pc<=next_pc, go S_REQ.
- next_pc priority:
  1. req: HANDLER_PC
  2. eret: epc
  3. branch_taken: branch_target
  4. otherwise pc+4 (32-bit wrap, no carry out)
- req is honoured in either state regardless of stall. pc<=HANDLER_PC, state<=S_REQ.
  - Any outstanding request is abandoned: imem_req drops next cycle.
  - An imem_ack coinciding with req is ignored.
- eret and branch_taken are only consumed on an S_VALID && !stall edge. In S_REQ the hazard unit holds ID, so both stay asserted until consumed.
- No flush output from this block. The squash of the post-eret instruction is done by IF/ID flush.
- Outputs:
  - IF_PC=pc.
  - IF_instr = (state==S_VALID) ? instr_buf : 0.
  - IF_ExcCode = (state==S_VALID) ? exc_buf : 0.
  - IF_BD = id_is_branch && state==S_VALID.
  - IF_PC is not masked; IF/ID must not capture while if_busy=1.
- An AdEL instruction is never fetched from memory. IF_instr=0 with ExcCode=4 and IF_PC = the faulting PC (BadVAddr source).
- Memory protocol: ack only while imem_req=1. Dropping req cancels with no response expected.

Decomposition:
- Shared CPU package holds:
  - ExcCode constants: EXC_NONE=0, EXC_ADEL=4.
  - RESET_PC and HANDLER_PC.
  - The TEXT_LO/TEXT_HI map constants.
  - FSM state encoding (S_REQ, S_VALID).
- One natural sub-module: if_next_pc. Purely combinational priority mux plus pc+4.
- FSM, pc and buffer registers stay in the top.

Test Plan:
1. Reset low 3 cycles, release; imem_ack after 2 cycles with rdata=32'h2408_0001 -> imem_addr=3000, if_busy 1 then 0, IF_PC=3000, IF_instr=24080001, ExcCode=0; next request at 3004.
2. stall=1 for 4 cycles in S_VALID -> IF_PC/IF_instr frozen, imem_req=0. stall=0 -> next imem_addr=3004.
3. id_is_branch=1 with IF at 3004, then branch_taken=1, target=3100 on advance -> IF_BD=1 for 3004; next imem_addr=3100 with IF_BD=0 after.
4. branch_target=3102 -> no imem_req; next cycle IF_instr=0, IF_ExcCode=4, IF_PC=3102. Same for target 7000 (out of range).
5. req=1 while waiting for ack, ack in same cycle -> ack ignored; next imem_addr=4180; req overrides simultaneous eret/branch_taken.
6. eret=1, epc=3208, stall=0 in S_VALID -> next imem_addr=3208. Async reset asserted mid-S_REQ -> immediate IF_PC=3000, IF_instr=0, imem_addr=3000.
